// File: rtl/spi_load_bridge.sv
// SPI-to-RAM load bridge: decodes ESP32 SPI cycles into control/status registers and
// RAM accesses, buffering RAM writes in a FIFO that drains while the CPU is held in wait.
`timescale 1ns/1ps
module spi_load_bridge #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  CTRL_RESET = 8'h00
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        spi_wr,
    input  logic        spi_rd,
    input  logic [31:0] spi_addr,
    input  logic [7:0]  spi_di,
    output logic [7:0]  spi_do,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_we,
    output logic        ram_we,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_din,
    input  logic [7:0]  ram_dout,
    output logic        cpu_wait_n,
    output logic        cpu_reset,
    output logic [7:0]  ctrl,
    output logic        busy
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned DW = 8;
    localparam int unsigned RAW = 16;
    localparam int unsigned EW = RAW + DW;

    logic [EW-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] occupancy;
    logic          fifo_empty;
    logic          fifo_full;
    logic          overflow;
    logic          ram_rd_pend;
    logic [EW-1:0] head;

    logic          sel_ram;
    logic          sel_reg;
    logic          load_mode;
    logic          ram_wr_req;
    logic          ram_rd_req;
    logic          reg_wr_req;
    logic          dir_rd_req;
    logic          push;
    logic          drain;
    logic [DW-1:0] reg_rdata;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^spi_addr[23:16];

    // Bus decode; a read issued together with a write is dropped.
    assign sel_ram    = (spi_addr[31:24] == 8'h00);
    assign sel_reg    = (spi_addr[31:24] == 8'hFF);
    assign ram_wr_req = spi_wr & sel_ram;
    assign reg_wr_req = spi_wr & sel_reg;
    assign ram_rd_req = spi_rd & ~spi_wr & sel_ram;
    assign dir_rd_req = spi_rd & ~spi_wr & ~sel_ram;

    // Pointers carry one extra wrap bit so full and empty differ only in the MSB.
    assign occupancy  = wr_ptr - rd_ptr;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head       = fifo_mem[rd_ptr[AW-1:0]];

    assign load_mode  = ctrl[1];
    assign busy       = ~fifo_empty;
    assign cpu_reset  = ctrl[0];
    assign push       = ram_wr_req & ~fifo_full;
    assign drain      = (load_mode | busy) & ~fifo_empty & ~ram_rd_req;

    always_comb begin
        reg_rdata = 8'h00;
        if (sel_reg) begin
            if (spi_addr[7:0] == 8'h00) begin
                reg_rdata = ctrl;
            end else if (spi_addr[7:0] == 8'h01) begin
                reg_rdata = {overflow, 2'b00, 5'(occupancy)};
            end
        end
    end

    // Port A arbitration: SPI read, then FIFO drain, then the CPU.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = cpu_addr;
        ram_din  = cpu_dout;
        if (ram_rd_req) begin
            ram_addr = spi_addr[15:0];
        end else if (drain) begin
            ram_we   = 1'b1;
            ram_addr = head[EW-1:DW];
            ram_din  = head[DW-1:0];
        end else begin
            ram_we   = cpu_we & ~load_mode & ~busy;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= {spi_addr[15:0], spi_di};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (drain) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (ram_wr_req && fifo_full) begin
                overflow <= 1'b1;
            end else if (reg_wr_req && (spi_addr[7:0] == 8'h01) && spi_di[0]) begin
                overflow <= 1'b0;
            end
        end
    end

    // Control register, wait handshake and SPI read-data return.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl        <= CTRL_RESET;
            cpu_wait_n  <= ~CTRL_RESET[1];
            spi_do      <= 8'h00;
            ram_rd_pend <= 1'b0;
        end else begin
            if (reg_wr_req && (spi_addr[7:0] == 8'h00)) begin
                ctrl <= spi_di;
            end
            cpu_wait_n  <= ~(load_mode | busy);
            ram_rd_pend <= ram_rd_req;
            if (dir_rd_req) begin
                spi_do <= reg_rdata;
            end else if (ram_rd_pend) begin
                spi_do <= ram_dout;
            end
        end
    end

endmodule

// File: tb/tb_spi_load_bridge.sv
// Self-checking bench for spi_load_bridge: directed scenarios plus random SPI/CPU traffic
// checked against a queue-based model of the bridge and a behavioural RAM.
`timescale 1ns/1ps
module tb_spi_load_bridge;
    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        int unsigned cyc;
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        spi_wr;
    logic        spi_rd;
    logic [31:0] spi_addr;
    logic [7:0]  spi_di;
    logic [7:0]  spi_do;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_we;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic        cpu_wait_n;
    logic        cpu_reset;
    logic [7:0]  ctrl;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Reference model state
    wr_t         m_fifo[$];
    wr_t         obs_q[$];
    wr_t         exp_q[$];
    logic [7:0]  m_ram [logic [15:0]];
    logic [7:0]  m_ctrl;
    logic        m_ovf;
    logic [7:0]  m_do;
    logic        m_pend;
    logic [7:0]  m_pend_val;
    logic        m_wait_n;
    int unsigned cyc;

    logic [7:0]  ram_mem [65536];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_din;
        ram_dout <= ram_mem[ram_addr];
    end

    spi_load_bridge #(.FIFO_DEPTH(DEPTH), .CTRL_RESET(8'h00)) dut (
        .clk(clk), .reset_n(reset_n),
        .spi_wr(spi_wr), .spi_rd(spi_rd), .spi_addr(spi_addr), .spi_di(spi_di), .spi_do(spi_do),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_we(cpu_we),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .cpu_wait_n(cpu_wait_n), .cpu_reset(cpu_reset), .ctrl(ctrl), .busy(busy)
    );

    task automatic model_reset();
        m_fifo.delete();
        m_ctrl = 8'h00;
        m_ovf = 1'b0;
        m_do = 8'h00;
        m_pend = 1'b0;
        m_pend_val = 8'h00;
        m_wait_n = 1'b1;
    endtask

    function automatic logic [7:0] m_ram_rd(input logic [15:0] a);
        return m_ram.exists(a) ? m_ram[a] : 8'h00;
    endfunction

    // One clock of traffic: drive at the falling edge, log port-A writes, advance the model.
    task automatic step(input logic wr, input logic rd, input logic [31:0] a, input logic [7:0] d,
                        input logic cw);
        logic is_ram, is_reg, rd_ram;
        logic [7:0] nxt_do;
        int occ;
        wr_t e;
        spi_wr = wr; spi_rd = rd; spi_addr = a; spi_di = d; cpu_we = cw;
        #1;
        if (ram_we) begin
            e.cyc = cyc; e.a = ram_addr; e.d = ram_din;
            obs_q.push_back(e);
        end
        is_ram = (a[31:24] == 8'h00);
        is_reg = (a[31:24] == 8'hFF);
        rd_ram = rd && !wr && is_ram;
        occ = m_fifo.size();
        nxt_do = m_do;
        if (m_pend) nxt_do = m_pend_val;
        if (rd && !wr && !is_ram) begin
            if (is_reg && a[7:0] == 8'h00)      nxt_do = m_ctrl;
            else if (is_reg && a[7:0] == 8'h01) nxt_do = {m_ovf, 2'b00, 5'(occ)};
            else                                nxt_do = 8'h00;
        end
        m_pend = rd_ram;
        m_pend_val = rd_ram ? m_ram_rd(a[15:0]) : 8'h00;
        m_wait_n = !(m_ctrl[1] || occ != 0);
        if (occ != 0 && !rd_ram) begin
            e = m_fifo.pop_front();
            e.cyc = cyc;
            exp_q.push_back(e);
            m_ram[e.a] = e.d;
        end else if (!rd_ram && cw && !m_ctrl[1] && occ == 0) begin
            e.cyc = cyc; e.a = cpu_addr; e.d = cpu_dout;
            exp_q.push_back(e);
            m_ram[e.a] = e.d;
        end
        if (wr && is_ram) begin
            if (occ < int'(DEPTH)) begin
                e.cyc = 0; e.a = a[15:0]; e.d = d;
                m_fifo.push_back(e);
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (wr && is_reg && a[7:0] == 8'h00) m_ctrl = d;
        if (wr && is_reg && a[7:0] == 8'h01 && d[0]) m_ovf = 1'b0;
        m_do = nxt_do;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        spi_wr = 1'b0; spi_rd = 1'b0; cpu_we = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 8'h00, 1'b0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; spi_wr = 1'b0; spi_rd = 1'b0; spi_addr = '0; spi_di = '0;
        cpu_we = 1'b0; cpu_addr = 16'h4000; cpu_dout = 8'hA5; cyc = 0;
        model_reset();
        @(negedge clk); #1;
        checks++; if (ctrl !== 8'h00) begin errors++; $display("FAIL reset_ctrl got %h exp 00", ctrl); end
        checks++; if (cpu_wait_n !== 1'b1) begin errors++; $display("FAIL reset_wait_n got %b exp 1", cpu_wait_n); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL reset_cpu_reset got %b exp 0", cpu_reset); end
        checks++; if (spi_do !== 8'h00) begin errors++; $display("FAIL reset_spi_do got %h exp 00", spi_do); end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we_idle got %b exp 0", ram_we); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        cpu_we = 1'b1; #1;
        checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL cpu_path_we got %b exp 1", ram_we); end
        checks++; if (ram_addr !== 16'h4000) begin errors++; $display("FAIL cpu_path_addr got %h exp 4000", ram_addr); end
        checks++; if (ram_din !== 8'hA5) begin errors++; $display("FAIL cpu_path_din got %h exp a5", ram_din); end
        cpu_we = 1'b0;
        m_ram[16'h4000] = 8'hA5;
        @(negedge clk);
    endtask

    task automatic test_load_mode();
        step(1'b1, 1'b0, 32'hFF00_0000, 8'h02, 1'b0);
        checks++; if (ctrl !== m_ctrl) begin errors++; $display("FAIL load_ctrl got %h exp %h", ctrl, m_ctrl); end
        step(1'b1, 1'b0, 32'h0000_0000, 8'h3E, 1'b0);
        step(1'b1, 1'b0, 32'h0000_0001, 8'h41, 1'b0);
        step(1'b1, 1'b0, 32'h0000_0002, 8'h76, 1'b0);
        checks++; if (cpu_wait_n !== 1'b0) begin errors++; $display("FAIL load_wait_n got %b exp 0", cpu_wait_n); end
        idle(4);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL load_busy_done got %b exp 0", busy); end
        checks++;
        if (obs_q.size() !== 3 || exp_q.size() !== 3) begin
            errors++; $display("FAIL load_wr_count got %0d exp 3", obs_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i] || obs_q[i].a !== 16'(i)) begin
                    errors++;
                    $display("FAIL load_wr%0d got c%0d %h<=%h exp c%0d %h<=%h", i, obs_q[i].cyc, obs_q[i].a,
                             obs_q[i].d, exp_q[i].cyc, exp_q[i].a, exp_q[i].d);
                end
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_clear_pending();
        step(1'b1, 1'b0, 32'h0000_0020, 8'h11, 1'b0);
        step(1'b1, 1'b0, 32'h0000_0021, 8'h22, 1'b0);
        step(1'b1, 1'b0, 32'h0000_0022, 8'h33, 1'b0);
        step(1'b1, 1'b0, 32'hFF00_0000, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++; if (cpu_wait_n !== m_wait_n) begin errors++; $display("FAIL clr_wait_n%0d got %b exp %b", i, cpu_wait_n, m_wait_n); end
            checks++; if (busy !== (m_fifo.size() != 0)) begin errors++; $display("FAIL clr_busy%0d got %b exp %b", i, busy, m_fifo.size() != 0); end
            idle(1);
        end
        checks++; if (cpu_wait_n !== 1'b1) begin errors++; $display("FAIL clr_wait_final got %b exp 1", cpu_wait_n); end
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL clr_wr_count got %0d exp %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL clr_wr%0d got c%0d %h<=%h exp c%0d %h<=%h", i, obs_q[i].cyc,
                                       obs_q[i].a, obs_q[i].d, exp_q[i].cyc, exp_q[i].a, exp_q[i].d);
                end
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back_status();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0000_0030 + 32'(i), 8'hC0 + 8'(i), 1'b0);
        checks++; if (cpu_wait_n !== 1'b0) begin errors++; $display("FAIL b2b_wait_n got %b exp 0", cpu_wait_n); end
        step(1'b0, 1'b1, 32'hFF00_0001, 8'h00, 1'b0);
        checks++; if (spi_do !== m_do) begin errors++; $display("FAIL b2b_status got %h exp %h", spi_do, m_do); end
        step(1'b1, 1'b0, 32'hFF00_0001, 8'h01, 1'b0);
        idle(2);
        step(1'b0, 1'b1, 32'hFF00_0001, 8'h00, 1'b0);
        checks++; if (spi_do !== 8'h00) begin errors++; $display("FAIL b2b_status_clr got %h exp 00", spi_do); end
        step(1'b0, 1'b1, 32'h1200_0000, 8'h00, 1'b0);
        checks++; if (spi_do !== m_do) begin errors++; $display("FAIL other_region_rd got %h exp %h", spi_do, m_do); end
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL b2b_wr_count got %0d exp %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL b2b_wr%0d got c%0d %h<=%h exp c%0d %h<=%h", i, obs_q[i].cyc,
                                       obs_q[i].a, obs_q[i].d, exp_q[i].cyc, exp_q[i].a, exp_q[i].d);
                end
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_read_stall();
        step(1'b1, 1'b0, 32'hFF00_0000, 8'h02, 1'b0);
        step(1'b1, 1'b0, 32'h0000_0040, 8'h9A, 1'b0);
        step(1'b1, 1'b0, 32'h0000_0041, 8'h9B, 1'b0);
        step(1'b0, 1'b1, 32'h0000_0001, 8'h00, 1'b0);
        checks++; if (spi_do !== m_do) begin errors++; $display("FAIL rd_lat1 got %h exp %h", spi_do, m_do); end
        idle(1);
        checks++; if (spi_do !== 8'h41) begin errors++; $display("FAIL rd_lat2 got %h exp 41", spi_do); end
        checks++; if (spi_do !== m_do) begin errors++; $display("FAIL rd_model got %h exp %h", spi_do, m_do); end
        idle(3);
        checks++; if (spi_do !== 8'h41) begin errors++; $display("FAIL rd_hold got %h exp 41", spi_do); end
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL stall_wr_count got %0d exp %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL stall_wr%0d got c%0d %h<=%h exp c%0d %h<=%h", i, obs_q[i].cyc,
                                       obs_q[i].a, obs_q[i].d, exp_q[i].cyc, exp_q[i].a, exp_q[i].d);
                end
            end
        end
        obs_q.delete(); exp_q.delete();
        step(1'b1, 1'b0, 32'hFF00_0000, 8'h00, 1'b0);
        idle(1);
    endtask

    task automatic test_reset_mid_drain();
        step(1'b1, 1'b0, 32'hFF00_0000, 8'h01, 1'b0);
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL cpu_reset_set got %b exp 1", cpu_reset); end
        step(1'b1, 1'b0, 32'h0000_0050, 8'h01, 1'b0);
        step(1'b1, 1'b0, 32'h0000_0051, 8'h02, 1'b0);
        step(1'b1, 1'b0, 32'h0000_0052, 8'h03, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_pre got %b exp 1", busy); end
        reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_rst got %b exp 0", busy); end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL mid_we_rst got %b exp 0", ram_we); end
        checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL mid_cpu_reset got %b exp 0", cpu_reset); end
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        idle(4);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_post got %b exp 0", busy); end
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL mid_wr_count got %0d exp %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL mid_wr%0d got c%0d %h<=%h exp c%0d %h<=%h", i, obs_q[i].cyc,
                                       obs_q[i].a, obs_q[i].d, exp_q[i].cyc, exp_q[i].a, exp_q[i].d);
                end
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [7:0]  rg;
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0, 3:    rg = 8'h00;
                1:       rg = 8'hFF;
                default: rg = 8'h5A;
            endcase
            a = {rg, 8'($urandom), 8'h01, 4'h0, 4'($urandom_range(0, 15))};
            if (rg == 8'hFF) a[7:0] = 8'($urandom_range(0, 3));
            cpu_addr = 16'h0100 + 16'($urandom_range(0, 15));
            cpu_dout = 8'($urandom);
            step($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 4, a, 8'($urandom),
                 $urandom_range(0, 3) == 0);
            checks++; if (ctrl !== m_ctrl) begin errors++; $display("FAIL rnd_ctrl@%0d got %h exp %h", n, ctrl, m_ctrl); end
            checks++; if (cpu_reset !== m_ctrl[0]) begin errors++; $display("FAIL rnd_cpu_reset@%0d got %b exp %b", n, cpu_reset, m_ctrl[0]); end
            checks++; if (busy !== (m_fifo.size() != 0)) begin errors++; $display("FAIL rnd_busy@%0d got %b exp %b", n, busy, m_fifo.size() != 0); end
            checks++; if (cpu_wait_n !== m_wait_n) begin errors++; $display("FAIL rnd_wait_n@%0d got %b exp %b", n, cpu_wait_n, m_wait_n); end
            checks++; if (spi_do !== m_do) begin errors++; $display("FAIL rnd_spi_do@%0d got %h exp %h", n, spi_do, m_do); end
        end
        idle(4);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL rnd_wr_count got %0d exp %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL rnd_wr%0d got c%0d %h<=%h exp c%0d %h<=%h", i, obs_q[i].cyc,
                                       obs_q[i].a, obs_q[i].d, exp_q[i].cyc, exp_q[i].a, exp_q[i].d);
                end
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram_mem[i] = 8'h00;
        test_reset();
        test_load_mode();
        test_clear_pending();
        test_back_to_back_status();
        test_read_stall();
        test_reset_mid_drain();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

endmodule
